add_arbiter: RTL and testbench

- Shares one instance of the team's 64-bit ripple adder (`add`: sum plus signed overflow) between two requesters, e.g. the execute stage and the address-generation/branch-target path.
- Each requester offers operands with a valid/ready handshake. A round-robin arbiter grants one requester per cycle.
- The sum, overflow flag and requester ID are captured in a single output register and presented under a valid/ready response handshake with back-pressure.

---
 rtl/add_arbiter_pkg.sv | 15 +
 rtl/add.sv | 22 ++
 rtl/add_arbiter.sv | 119 +++++++++++
 tb/tb_add_arbiter.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/add_arbiter_pkg.sv
// Shared definitions for the two-requester adder arbiter: datapath width,
// requester IDs and the response-register state encoding.
package add_arbiter_pkg;

    localparam int XLEN = 64;

    localparam logic [0:0] REQ_EXU = 1'b0;
    localparam logic [0:0] REQ_AGU = 1'b1;

    typedef enum logic {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } rsp_state_e;

endpackage

// File: rtl/add.sv
// Team 64-bit ripple-carry adder: C = A + B (mod 2^64) with signed overflow.
module add (
    output logic        ov,
    output logic [63:0] C,
    input  logic [63:0] A,
    input  logic [63:0] B
);

    logic w_carry;

    // Ripple the carry bit by bit; the final carry-out is deliberately dropped.
    always_comb begin
        w_carry = 1'b0;
        C       = 64'd0;
        for (int i = 0; i < 64; i++) begin
            C[i]    = A[i] ^ B[i] ^ w_carry;
            w_carry = (A[i] & B[i]) | (w_carry & (A[i] ^ B[i]));
        end
        ov = (A[63] == B[63]) && (C[63] != A[63]);
    end

endmodule

// File: rtl/add_arbiter.sv
// Round-robin sharing of one 64-bit adder between two valid/ready requesters,
// with a single registered response under valid/ready back-pressure.
module add_arbiter
    import add_arbiter_pkg::*;
#(
    parameter int WIDTH = XLEN,
    parameter int ID_W  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [ID_W-1:0]  rsp_id,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_ov
);

    rsp_state_e       r_state;
    rsp_state_e       w_state_nxt;
    logic [ID_W-1:0]  r_prio;
    logic [ID_W-1:0]  r_rsp_id;
    logic [WIDTH-1:0] r_rsp_sum;
    logic             r_rsp_ov;

    logic             w_accept;
    logic             w_grant0;
    logic             w_grant1;
    logic             w_fire;
    logic [ID_W-1:0]  w_grant_id;
    logic [WIDTH-1:0] w_op_a;
    logic [WIDTH-1:0] w_op_b;
    logic [WIDTH-1:0] w_sum;
    logic             w_ov;

    // The register can take a new result when empty or when it drains this cycle.
    assign w_accept = !reset && ((r_state == RSP_EMPTY) || rsp_ready);

    // A lone requester always wins; on contention prio picks the winner.
    assign w_grant0 = req0_valid && (!req1_valid || (r_prio == ID_W'(REQ_EXU)));
    assign w_grant1 = req1_valid && (!req0_valid || (r_prio == ID_W'(REQ_AGU)));

    assign req0_ready = w_accept && w_grant0;
    assign req1_ready = w_accept && w_grant1;
    assign w_fire     = req0_ready || req1_ready;
    assign w_grant_id = w_grant1 ? ID_W'(REQ_AGU) : ID_W'(REQ_EXU);

    // Requester 0 is the default mux leg when nobody is granted.
    assign w_op_a = w_grant1 ? req1_a : req0_a;
    assign w_op_b = w_grant1 ? req1_b : req0_b;

    add u_add (
        .ov (w_ov),
        .C  (w_sum),
        .A  (w_op_a),
        .B  (w_op_b)
    );

    // Response-state next-state logic: fire fills, a drained register empties.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RSP_EMPTY: begin
                if (w_fire) begin
                    w_state_nxt = RSP_FULL;
                end else begin
                    w_state_nxt = RSP_EMPTY;
                end
            end
            RSP_FULL: begin
                if (w_fire) begin
                    w_state_nxt = RSP_FULL;
                end else if (rsp_ready) begin
                    w_state_nxt = RSP_EMPTY;
                end else begin
                    w_state_nxt = RSP_FULL;
                end
            end
            default: w_state_nxt = RSP_EMPTY;
        endcase
    end

    // State, round-robin pointer and response payload registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= RSP_EMPTY;
            r_prio    <= ID_W'(REQ_EXU);
            r_rsp_id  <= '0;
            r_rsp_sum <= '0;
            r_rsp_ov  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_fire) begin
                r_prio    <= w_grant1 ? ID_W'(REQ_EXU) : ID_W'(REQ_AGU);
                r_rsp_id  <= w_grant_id;
                r_rsp_sum <= w_sum;
                r_rsp_ov  <= w_ov;
            end else begin
                r_prio    <= r_prio;
                r_rsp_id  <= r_rsp_id;
                r_rsp_sum <= r_rsp_sum;
                r_rsp_ov  <= r_rsp_ov;
            end
        end
    end

    assign rsp_valid = (r_state == RSP_FULL);
    assign rsp_id    = r_rsp_id;
    assign rsp_sum   = r_rsp_sum;
    assign rsp_ov    = r_rsp_ov;

endmodule

// File: tb/tb_add_arbiter.sv
// Directed, table-driven bench for add_arbiter: one row per clock cycle with
// hand-computed ready and response expectations.
module tb_add_arbiter;

    logic        clk;
    logic        reset;
    logic        req0_valid;
    logic [63:0] req0_a;
    logic [63:0] req0_b;
    logic        req0_ready;
    logic        req1_valid;
    logic [63:0] req1_a;
    logic [63:0] req1_b;
    logic        req1_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [0:0]  rsp_id;
    logic [63:0] rsp_sum;
    logic        rsp_ov;

    int n_checks = 0;
    int n_errors = 0;

    add_arbiter #(.WIDTH(64), .ID_W(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum),
        .rsp_ov     (rsp_ov)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        v0;
        logic [63:0] a0;
        logic [63:0] b0;
        logic        v1;
        logic [63:0] a1;
        logic [63:0] b1;
        logic        rr;
        logic        e_r0;
        logic        e_r1;
        logic        e_v;
        logic        chk_d;
        logic [0:0]  e_id;
        logic [63:0] e_sum;
        logic        e_ov;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic v0, input logic [63:0] a0, input logic [63:0] b0,
                         input logic v1, input logic [63:0] a1, input logic [63:0] b1, input logic rr);
        reset      = rst;
        req0_valid = v0;
        req0_a     = a0;
        req0_b     = b0;
        req1_valid = v1;
        req1_a     = a1;
        req1_b     = b1;
        rsp_ready  = rr;
    endtask

    initial begin
        //           rst   v0    a0                     b0     v1    a1                     b1                     rr    r0    r1    v     chk   id    sum                    ov
        vecs[0]  = '{1'b1, 1'b0, 64'd0,                 64'd0, 1'b0, 64'd0,                 64'd0,                 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0,                 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 64'd5,                 64'd7, 1'b0, 64'd0,                 64'd0,                 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 64'd12,                1'b0};
        vecs[2]  = '{1'b0, 1'b0, 64'd0,                 64'd0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,               1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 64'h8000_0000_0000_0000, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 64'd3,                 64'd4, 1'b1, 64'd100,               64'd200,               1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 64'd7,                 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 64'd3,                 64'd4, 1'b1, 64'd100,               64'd200,               1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 64'd300,               1'b0};
        vecs[5]  = '{1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 64'd100,             64'd200,               1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 64'd0,                 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 64'd9,                 64'd9, 1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 64'd0,              1'b1};
        vecs[7]  = '{1'b0, 1'b0, 64'd0,                 64'd0, 1'b0, 64'd0,                 64'd0,                 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0,                 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 64'd0,                 64'd0, 1'b1, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 64'h8000_0000_0000_0000, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 64'd0,                 64'd0, 1'b1, 64'd5,                 64'd6,                 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h8000_0000_0000_0000, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 64'd0,                 64'd0, 1'b1, 64'd5,                 64'd6,                 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h8000_0000_0000_0000, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 64'd0,                 64'd0, 1'b1, 64'd5,                 64'd6,                 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h8000_0000_0000_0000, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 64'd0,                 64'd0, 1'b1, 64'd5,                 64'd6,                 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 64'd11,                1'b0};
        vecs[13] = '{1'b0, 1'b1, 64'd20,                64'd22, 1'b0, 64'd0,                64'd0,                 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 64'd42,                1'b0};
        vecs[14] = '{1'b1, 1'b1, 64'd7,                 64'd8, 1'b0, 64'd0,                 64'd0,                 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0,                 1'b0};
        vecs[15] = '{1'b0, 1'b1, 64'd7,                 64'd8, 1'b1, 64'd1,                 64'd1,                 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 64'd15,                1'b0};
        vecs[16] = '{1'b0, 1'b1, 64'd7,                 64'd8, 1'b1, 64'd1,                 64'd1,                 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 64'd15,                1'b0};
        vecs[17] = '{1'b0, 1'b1, 64'd7,                 64'd8, 1'b1, 64'd1,                 64'd1,                 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 64'd2,                 1'b0};

        drive(1'b1, 1'b0, 64'd0, 64'd0, 1'b0, 64'd0, 64'd0, 1'b0);
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst, vecs[i].v0, vecs[i].a0, vecs[i].b0,
                  vecs[i].v1, vecs[i].a1, vecs[i].b1, vecs[i].rr);
            #1;
            check($sformatf("row%0d req0_ready", i), {63'd0, req0_ready}, {63'd0, vecs[i].e_r0});
            check($sformatf("row%0d req1_ready", i), {63'd0, req1_ready}, {63'd0, vecs[i].e_r1});
            @(posedge clk);
            #1;
            check($sformatf("row%0d rsp_valid", i), {63'd0, rsp_valid}, {63'd0, vecs[i].e_v});
            if (vecs[i].chk_d) begin
                check($sformatf("row%0d rsp_id", i),  {63'd0, rsp_id}, {63'd0, vecs[i].e_id});
                check($sformatf("row%0d rsp_sum", i), rsp_sum, vecs[i].e_sum);
                check($sformatf("row%0d rsp_ov", i),  {63'd0, rsp_ov}, {63'd0, vecs[i].e_ov});
            end
            @(negedge clk);
        end

        // Hand sequence: pass-through with a waiting requester, bounded wait for its grant.
        drive(1'b0, 1'b1, 64'd1000, 64'd24, 1'b0, 64'd0, 64'd0, 1'b0);
        #1;
        check("hold req0_ready", {63'd0, req0_ready}, 64'd0);
        @(negedge clk);
        rsp_ready = 1'b1;
        begin
            int waited;
            waited = 0;
            #1;
            while (!req0_ready && waited < 8) begin
                @(negedge clk);
                #1;
                waited++;
            end
            check("grant wait cycles", 64'(waited), 64'd0);
        end
        @(posedge clk);
        #1;
        check("pass rsp_id",  {63'd0, rsp_id}, 64'd0);
        check("pass rsp_sum", rsp_sum, 64'd1024);
        @(negedge clk);

        // Drain: nobody valid, consumer ready, register empties.
        drive(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 64'd0, 64'd0, 1'b1);
        @(posedge clk);
        #1;
        check("drain rsp_valid", {63'd0, rsp_valid}, 64'd0);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
